// File: rtl/mod_addsub_ctrl_pkg.sv
// Shared definitions for the modular add/sub sequencer: datapath width,
// adder latency, FSM state encoding and the P-384 field prime.
package mod_addsub_ctrl_pkg;

  localparam int ADDSUB_WIDTH  = 384;
  localparam int ADDER_LATENCY = 3;

  // P-384 prime: 2^384 - 2^128 - 2^96 + 2^32 - 1
  localparam logic [383:0] P384 =
    384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OP1   = 3'd1,
    S_WAIT1 = 3'd2,
    S_OP2   = 3'd3,
    S_WAIT2 = 3'd4,
    S_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/mod_addsub_ctrl_adder.sv
// Pipelined WIDTH-bit adder/subtractor with a fixed start->done latency.
// result[WIDTH] is the carry-out for an add and the borrow-out for a subtract.
module mod_addsub_ctrl_adder #(
  parameter int WIDTH   = 384,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done
);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   pipe_q [LATENCY];
  logic [LATENCY-1:0] vld_q;

  // Zero-extended operands make bit WIDTH the carry (add) or borrow (sub).
  assign sum_w = subtract ? ({1'b0, in_a} - {1'b0, in_b})
                          : ({1'b0, in_a} + {1'b0, in_b});

  // Valid token travels alongside the data; only it needs a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= start;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data pipeline, qualified by vld_q.
  // NOTE: the data stages carry no reset; they are never observed without their valid bit.
  always_ff @(posedge clk) begin
    if (start) pipe_q[0] <= sum_w;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign result = pipe_q[LATENCY-1];
  assign done   = vld_q[LATENCY-1];

endmodule

// File: rtl/mod_addsub_ctrl.sv
// Sequencer computing (in_a +/- in_b) mod modulus with two passes through one
// shared adder: the raw add/sub, then a correction by the modulus. Both passes
// always run so the latency is independent of the operand values.
module mod_addsub_ctrl
  import mod_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH,
  parameter int L_ADD = ADDER_LATENCY
) (
  input  logic             clk,
  input  logic             resetn,   // active-high despite the name
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic             sub_q;
  logic [WIDTH:0]   r1_q;
  logic [WIDTH-1:0] result_q;

  logic             add_start, add_sub, add_done, adder_rst_n;
  logic [WIDTH-1:0] add_a, add_b;
  logic [WIDTH:0]   add_res;
  logic             take_r2;

  assign adder_rst_n = ~resetn;

  mod_addsub_ctrl_adder #(
    .WIDTH  (WIDTH),
    .LATENCY(L_ADD)
  ) u_adder (
    .clk     (clk),
    .rst_n   (adder_rst_n),
    .start   (add_start),
    .subtract(add_sub),
    .in_a    (add_a),
    .in_b    (add_b),
    .result  (add_res),
    .done    (add_done)
  );

  // State register.
  // NOTE: every clocked assignment is non-blocking so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the adder's done is only consulted in the two wait states.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)    state_d = S_OP1;
      S_OP1:                 state_d = S_WAIT1;
      S_WAIT1: if (add_done) state_d = S_OP2;
      S_OP2:                 state_d = S_WAIT2;
      S_WAIT2: if (add_done) state_d = S_FIN;
      S_FIN:                 state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Adder operand steering; operands stay stable across each start..done window.
  always_comb begin
    add_start = 1'b0;
    add_a     = a_q;
    add_b     = b_q;
    add_sub   = sub_q;
    unique case (state_q)
      S_OP1:   add_start = 1'b1;
      S_OP2: begin
        add_start = 1'b1;
        add_a     = r1_q[WIDTH-1:0];
        add_b     = p_q;
        add_sub   = ~sub_q;
      end
      S_WAIT2: begin
        add_a     = r1_q[WIDTH-1:0];
        add_b     = p_q;
        add_sub   = ~sub_q;
      end
      default: ;
    endcase
  end

  // Add: use r1-P when the raw sum overflowed or r1-P did not borrow.
  // Sub: use r1+P only when the raw difference borrowed.
  assign take_r2 = sub_q ? r1_q[WIDTH] : (r1_q[WIDTH] | ~add_res[WIDTH]);

  // Operand latch, first-pass capture and final selection.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      sub_q    <= 1'b0;
      r1_q     <= '0;
      result_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        a_q   <= in_a;
        b_q   <= in_b;
        p_q   <= modulus;
        sub_q <= subtract;
      end
      if (state_q == S_WAIT1 && add_done) r1_q <= add_res;
      if (state_q == S_WAIT2 && add_done)
        result_q <= take_r2 ? add_res[WIDTH-1:0] : r1_q[WIDTH-1:0];
    end
  end

  assign result = result_q;
  assign done   = (state_q == S_FIN);
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Self-checking bench for mod_addsub_ctrl: directed corner cases, a start
// pulse during WAIT1, a reset during WAIT2, then 1000 random back-to-back ops.
module tb_mod_addsub_ctrl;
  import mod_addsub_ctrl_pkg::*;

  localparam int W = ADDSUB_WIDTH;
  localparam int L = ADDER_LATENCY;
  // Start cycle to done cycle, counting both ends, spans 2*L+4 cycles.
  localparam int LAT = 2 * L + 3;

  typedef logic [W-1:0] word_t;

  logic  clk = 1'b0;
  logic  resetn;
  logic  start;
  logic  subtract;
  word_t in_a, in_b, modulus;
  word_t result;
  logic  done, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mod_addsub_ctrl dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .subtract(subtract),
    .in_a    (in_a),
    .in_b    (in_b),
    .modulus (modulus),
    .result  (result),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input word_t obs, input word_t exp, input string tag);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on a wider integer.
  function automatic word_t ref_mod(input word_t a, input word_t b, input word_t p, input logic sub);
    logic [W+1:0] t;
    if (sub) t = {2'b0, a} + {2'b0, p} - {2'b0, b};
    else     t = {2'b0, a} + {2'b0, b};
    t = t % {2'b0, p};
    return t[W-1:0];
  endfunction

  function automatic word_t rand_word();
    word_t v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One operation starting on the next cycle. A nonzero glitch gives the
  // cycle offset at which a second, conflicting start pulse is injected.
  task automatic run_op(input word_t a, input word_t b, input logic sub,
                        input string tag, input int glitch);
    word_t exp;
    int    k, lat;
    bit    seen, busy_bad;
    exp = ref_mod(a, b, P384, sub);
    @(posedge clk); #1;
    start = 1'b1; subtract = sub; in_a = a; in_b = b; modulus = P384;
    k = cyc;
    @(negedge clk);
    check(word_t'(busy), word_t'(0), {tag, "/idle_busy"});
    check(word_t'(done), word_t'(0), {tag, "/idle_done"});
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0; busy_bad = 1'b0; lat = -1;
    for (int i = 1; i <= LAT + 8 && !seen; i++) begin
      @(negedge clk);
      if (glitch != 0 && i == glitch) begin
        start = 1'b1; subtract = ~sub; in_a = rand_word() % P384; in_b = rand_word() % P384;
      end
      if (glitch != 0 && i == glitch + 1) start = 1'b0;
      if (!busy) busy_bad = 1'b1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - k;
      end
    end
    start = 1'b0;
    check(word_t'(seen), word_t'(1), {tag, "/done_seen"});
    check(word_t'(lat), word_t'(LAT), {tag, "/latency"});
    check(word_t'(busy_bad), word_t'(0), {tag, "/busy_low"});
    check(result, exp, {tag, "/result"});
  endtask

  initial begin
    word_t pm1;
    bit    done_bad;
    pm1      = P384 - 1;
    resetn   = 1'b1;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;
    modulus  = P384;

    repeat (3) @(negedge clk);
    check(result, word_t'(0), "reset/result");
    check(word_t'(done), word_t'(0), "reset/done");
    check(word_t'(busy), word_t'(0), "reset/busy");
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    run_op(word_t'(5), word_t'(7), 1'b0, "add_5_7", 0);
    check(result, word_t'(12), "add_5_7/const");
    run_op(pm1, word_t'(2), 1'b0, "add_pm1_2", 0);
    check(result, word_t'(1), "add_pm1_2/const");
    run_op(pm1, pm1, 1'b0, "add_carry", 0);
    check(result, P384 - 2, "add_carry/const");
    run_op(word_t'(9), word_t'(4), 1'b1, "sub_9_4", 0);
    check(result, word_t'(5), "sub_9_4/const");
    run_op(word_t'(3), word_t'(5), 1'b1, "sub_3_5", 0);
    check(result, P384 - 2, "sub_3_5/const");
    run_op(pm1, pm1, 1'b1, "sub_equal", 0);
    check(result, word_t'(0), "sub_equal/const");

    // Conflicting start during WAIT1 must be ignored.
    run_op(word_t'(100), word_t'(23), 1'b0, "start_in_wait1", 2);
    check(result, word_t'(123), "start_in_wait1/const");

    // Reset during WAIT2: no done, outputs cleared.
    @(posedge clk); #1;
    start = 1'b1; subtract = 1'b0; in_a = word_t'(40); in_b = word_t'(2);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (L + 4) @(negedge clk);
    resetn = 1'b1;
    #1;
    check(result, word_t'(0), "mid_reset/result");
    check(word_t'(busy), word_t'(0), "mid_reset/busy");
    check(word_t'(done), word_t'(0), "mid_reset/done");
    @(negedge clk);
    resetn   = 1'b0;
    done_bad = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (done || busy) done_bad = 1'b1;
    end
    check(word_t'(done_bad), word_t'(0), "mid_reset/no_done");
    check(result, word_t'(0), "mid_reset/result_after");
    run_op(word_t'(1), word_t'(1), 1'b0, "after_reset", 0);
    check(result, word_t'(2), "after_reset/const");

    // Random back-to-back operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      run_op(rand_word() % P384, rand_word() % P384, 1'($urandom), "rand", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
